// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand/result bundle for the bit-serial adder
`timescale 1ns/1ps
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial a+b+cin through one full-adder cell, WIDTH clocks per result
`timescale 1ns/1ps
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, ps_q, ps_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d, done_q, done_d;
  logic             accept, run, last, fin, s, c_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    accept  = (state_q == IDLE) && bus.start;
    run     = state_q == RUN;
    last    = cnt_q == CW'(WIDTH - 1);
    fin     = run && last;
    state_d = accept ? RUN : fin ? IDLE : state_q;
  end
  always_comb begin
    bus.busy = run;
    bus.done = done_q;
    bus.sum  = sum_q;
    bus.cout = cout_q;
  end
  always_comb begin
    s      = sa_q[0] ^ sb_q[0] ^ c_q;
    c_n    = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));
    sa_d   = accept ? bus.a : run ? sa_q >> 1 : sa_q;
    sb_d   = accept ? bus.b : run ? sb_q >> 1 : sb_q;
    c_d    = accept ? bus.cin : run ? c_n : c_q;
    cnt_d  = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    ps_d   = run ? {s, ps_q[WIDTH-1:1]} : ps_q;
    sum_d  = fin ? ps_d : sum_q;
    cout_d = fin ? c_n : cout_q;
    done_d = fin;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa_q   <= '0;
      sb_q   <= '0;
      ps_q   <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      ps_q   <= ps_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      c_q    <= c_d;
      cout_q <= cout_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table plus hand-written busy-start, reset and back-to-back sequences
`timescale 1ns/1ps
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  serial_adder_if #(8) bus ();
  serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       scramble;
    logic [7:0] sum;
    logic       cout;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic scramble, output int lat, output int bcnt);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 0;
    bcnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 50) begin
      if (scramble) begin
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.cin = 1'($urandom);
      end
      step();
      lat++;
      if (bus.busy) bcnt++;
    end
  endtask
  vec_t vecs[9];
  initial begin
    int lat, bcnt, dn, first, second, moved;
    logic [7:0] s1, s2, hold_s;
    logic c1, c2, hold_c;
    vecs[0] = '{8'd3,   8'd5,   1'b0, 1'b0, 8'd8,   1'b0};
    vecs[1] = '{8'd255, 8'd1,   1'b0, 1'b0, 8'd0,   1'b1};
    vecs[2] = '{8'd200, 8'd100, 1'b1, 1'b0, 8'd45,  1'b1};
    vecs[3] = '{8'd0,   8'd0,   1'b1, 1'b0, 8'd1,   1'b0};
    vecs[4] = '{8'd255, 8'd255, 1'b1, 1'b0, 8'd255, 1'b1};
    vecs[5] = '{8'd170, 8'd85,  1'b0, 1'b0, 8'd255, 1'b0};
    vecs[6] = '{8'd128, 8'd128, 1'b0, 1'b0, 8'd0,   1'b1};
    vecs[7] = '{8'd200, 8'd100, 1'b1, 1'b1, 8'd45,  1'b1};
    vecs[8] = '{8'd77,  8'd22,  1'b0, 1'b1, 8'd99,  1'b0};
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].scramble, lat, bcnt);
      chk($sformatf("v%0d_latency", i), lat, 8);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, 8);
      chk($sformatf("v%0d_sum", i), bus.sum, vecs[i].sum);
      chk($sformatf("v%0d_cout", i), bus.cout, vecs[i].cout);
      step();
      chk($sformatf("v%0d_done_width", i), bus.done, 0);
    end
    // result must hold through idle cycles
    hold_s = bus.sum;
    hold_c = bus.cout;
    moved = 0;
    for (int i = 0; i < 20; i++) begin
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      step();
      if (bus.sum !== 8'd99 || bus.cout !== 1'b0 || bus.done !== 1'b0) moved++;
    end
    chk("idle_hold", moved, 0);
    chk("idle_hold_sum", hold_s, 99);
    // start while busy must be ignored
    bus.a = 8'd3;
    bus.b = 8'd5;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.a = 8'd7;
    bus.b = 8'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    dn = 0;
    first = -1;
    for (int i = 4; i < 25; i++) begin
      step();
      if (bus.done) begin
        dn++;
        if (first < 0) first = i;
        s1 = bus.sum;
      end
    end
    chk("busy_start_done_count", dn, 1);
    chk("busy_start_done_edge", first, 8);
    chk("busy_start_sum", s1, 8);
    chk("busy_start_idle", bus.busy, 0);
    // reset in the middle of an operation
    bus.a = 8'd3;
    bus.b = 8'd5;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_sum", bus.sum, 0);
    chk("midrst_cout", bus.cout, 0);
    step();
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done || bus.busy) dn++;
    end
    chk("midrst_no_done", dn, 0);
    do_add(8'd10, 8'd20, 1'b0, 1'b0, lat, bcnt);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_sum", bus.sum, 30);
    step();
    // back-to-back with start held high
    bus.a = 8'd1;
    bus.b = 8'd2;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    step();
    bus.a = 8'd100;
    bus.b = 8'd27;
    first = -1;
    second = -1;
    for (int i = 1; i < 40 && second < 0; i++) begin
      step();
      if (bus.done && bus.busy) first = -2;
      if (bus.done && first == -1) begin
        first = i;
        s1 = bus.sum;
        c1 = bus.cout;
      end else if (bus.done && first > 0) begin
        second = i;
        s2 = bus.sum;
        c2 = bus.cout;
      end
      if (first > 0 && i == first + 1) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk("b2b_first_edge", first, 8);
    chk("b2b_spacing", second - first, 9);
    chk("b2b_sum1", s1, 3);
    chk("b2b_cout1", c1, 0);
    chk("b2b_sum2", s2, 127);
    chk("b2b_cout2", c2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder: latches two WIDTH-bit operands plus a carry-in on a start strobe, then adds one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It presents the registered sum and carry-out with a one-cycle done pulse. It is the additive counterpart of the combinational full subtractor in the adder/subtractor group. It is the area-minimal arithmetic unit for datapaths that can tolerate WIDTH-cycle latency.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2 to 32.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request strobe; accepted only when busy=0.
- a  input  WIDTH  operand A; sampled only on the accepting edge.
- b  input  WIDTH  operand B; sampled only on the accepting edge.
- cin  input  1  carry-in; sampled only on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle onward.
- sum  output  WIDTH  result (a + b + cin) mod 2^WIDTH; held until the next completion.
- cout  output  1  carry out of bit WIDTH-1; held with sum.

## Operation
- FSM states:
  - IDLE (busy=0).
  - RUN (busy=1).
- Internal registers:
  - Operand shift registers sa and sb, WIDTH bits each.
  - Carry flip-flop c.
  - Partial-sum shift register ps, WIDTH bits.
  - Bit counter cnt, clog2(WIDTH) bits.
- IDLE with start=1:
  - Load sa=a, sb=b, c=cin, cnt=0.
  - Go to RUN.
  - The operands are latched, so a, b and cin may change on the next cycle without affecting the result.
- RUN, each edge:
  - Form s = sa[0]^sb[0]^c.
  - Update c = (sa[0]&sb[0]) | (c&(sa[0]^sb[0])).
  - Shift ps right with s entering at the MSB.
  - Shift sa and sb right, filling with 0.
  - Increment cnt.
- RUN with cnt==WIDTH-1, on that same edge:
  - Load sum with the final shifted ps (the new s at the MSB).
  - Load cout with the new carry.
  - Set done=1 and return to IDLE.
- start while busy=1 is ignored: no queuing, and no effect on the operation in progress.
- done is high only in the cycle after the completing edge. sum and cout are unchanged at every other edge.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, and all internal registers 0.
- Reset mid-operation: the operation is abandoned immediately, with no done pulse and no partial sum visible on the outputs.

## Timing
- Take E0 as the edge that samples start=1 in IDLE.
  - busy rises after E0.
  - Bits 0..WIDTH-1 are processed on edges E1..E_WIDTH.
- Completion happens at E_WIDTH. After that edge:
  - done=1, busy=0, and sum/cout are updated.
- Latency is WIDTH clocks from the accepting edge to done.
- Throughput is one result per WIDTH+1 clocks. The earliest next accept is E_WIDTH+1, and start may be held high in the done cycle to get it.
- busy and done are never high in the same cycle.
- All outputs are registered, so there is no combinational path from inputs to outputs.

## Test plan
- Basic add, WIDTH=8: a=3, b=5, cin=0, start for one cycle.
  - busy is high for exactly 8 cycles.
  - done pulses once, with sum=8 and cout=0.
- Full carry ripple: a=255, b=1, cin=0 gives sum=0, cout=1. Then a=200, b=100, cin=1 gives sum=45, cout=1.
- Operand latching and stability:
  - Change a, b and cin on every cycle after accept. The result still matches the sampled values.
  - sum and cout stay stable for 20 idle cycles after done.
- Start during busy: pulse start=1 with a=7, b=7 at E3. The first result (a=3, b=5 gives 8) is unaffected, and exactly one done pulse occurs.
- Reset mid-operation: assert rst_n=0 at E4.
  - busy, done, sum and cout go to 0 immediately.
  - No done pulse follows.
  - A fresh add of 10 + 20 then gives sum=30.
- Back-to-back: hold start=1 continuously across two operations (1+2, then 100+27).
  - done pulses are spaced by 9 cycles.
  - Results are 3 and 127, each with cout=0.
